sfifo_flex: RTL and testbench
=============================

Name: sfifo_flex

Overview:
- Parametrised synchronous FIFO, successor to the team's basic single-clock FIFO.
- Adds:
  - any DEPTH ≥ 2, including non-power-of-two, with explicit pointer wrap;
  - exported occupancy count;
  - programmable almost-full / almost-empty thresholds;
  - overflow / underflow error pulses;
  - selectable read mode: registered read or first-word-fall-through (FWFT).
- Sits between producer/consumer stages in the datapath; drop-in for the basic FIFO when MODE=0.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries; ≥ 2; need not be a power of two.
- ADDR, $clog2(DEPTH), pointer width.
- CNT_W, $clog2(DEPTH+1), occupancy count width.
- AF_THRESH, DEPTH-1, almost_full asserted when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserted when count ≤ AE_THRESH; range 0..DEPTH-1.
- MODE, 0, 0 = registered read, 1 = FWFT.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset (reset when rst=0 at a rising edge of clk).
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- r_en  in  1  read request (MODE=0) / pop acknowledge (MODE=1).
- dout  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CNT_W  current occupancy.
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=0 at edge):
  - wr_ptr=0, r_ptr=0, count=0.
  - dout=0, full=0, empty=1, almost_full=0, almost_empty=1.
  - overflow=0, underflow=0.
  - Storage contents are not cleared.
  - Reset mid-operation discards all contents; in-flight requests in that cycle are ignored.
- Acceptance, evaluated on pre-edge state:
  - rd_ok = r_en & ~empty.
  - wr_ok = wr_en & (~full | rd_ok).
  - When full and both wr_en and r_en are asserted, both are accepted; count is unchanged.
  - When empty and both are asserted, only the write is accepted; underflow pulses.
- Pointers:
  - Advance by 1 on their accept.
  - Wrap from DEPTH-1 to 0 explicitly; never rely on natural binary wrap.
- Count:
  - +1 on wr_ok only; −1 on rd_ok only; unchanged when both or neither.
  - Never exceeds DEPTH and never underflows.
- Flags:
  - full, empty, almost_full, almost_empty are registered, derived from next-count.
  - They are therefore consistent with count in the same cycle.
- Error pulses:
  - overflow=1 for exactly one cycle after an edge where wr_en & ~wr_ok.
  - underflow=1 for exactly one cycle after an edge where r_en & empty.
  - FIFO state is unchanged by the rejected operation.
- MODE=0 (registered read):
  - On rd_ok, dout <= mem[r_ptr]; data is visible the cycle after the accepting edge.
  - dout otherwise holds its last value.
- MODE=1 (FWFT):
  - dout = mem[r_ptr] combinationally, valid whenever empty=0; value is don't-care when empty=1.
  - r_en pops the head; the next word appears after the edge.
  - A word written into an empty FIFO is visible on dout one cycle after its write edge (empty deasserts at the same time).
- Write-to-read on the same address in the same cycle cannot occur:
  - MODE=0: a read requires ~empty, so that address already holds older data.
  - MODE=1: the combinational read is of committed storage.

Decomposition:
- Shared package sfifo_pkg: MODE_REG=0, MODE_FWFT=1 constants; function for CNT_W / ADDR sizing; parameter-legality checks (DEPTH ≥ 2, threshold ranges) as elaboration-time assertions.
- One sub-module, sfifo_ram:
  - simple dual-port array, DEPTH × WIDTH;
  - synchronous write port;
  - combinational read port (registered externally in MODE=0).
- Pointer, count, flag and error logic live in sfifo_flex.

Test Plan:
- DEPTH=5, WIDTH=8, MODE=0, AF_THRESH=4, AE_THRESH=1; reset low 2 cycles, then write 11,22,33,44 -> count=4, almost_full=1, full=0, almost_empty=0; write 55 -> full=1; write 66 -> overflow pulses 1 cycle, count stays 5, 66 not stored.
- From full, 5 reads -> dout 11,22,33,44,55, each one cycle after its read edge; empty=1; a 6th read -> underflow pulse, dout holds 55.
- Pointer wrap: 3 writes, 3 reads, then 4 writes A1,B2,C3,D4 and 4 reads -> data returned in order across the DEPTH-1→0 boundary; count returns to 0.
- Full + simultaneous wr_en=1/r_en=1 with din=F6 -> no overflow, count stays 5, head word read out, F6 later read last.
- Empty + simultaneous wr_en/r_en with din=E5 -> underflow pulse, count=1, next read returns E5.
- MODE=1: write 5A to empty FIFO -> dout=5A and empty=0 one cycle after the write edge with no read; r_en pops -> empty=1. Assert rst=0 with count=3 -> next cycle count=0, empty=1, all flags at reset values.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared definitions for the sfifo_flex family: read-mode codes, sizing
// helpers and the parameter-legality predicate used at elaboration time.
package sfifo_pkg;

  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int clog2_int(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int addr_bits(input int depth);
    return clog2_int(depth);
  endfunction

  function automatic int cnt_bits(input int depth);
    return clog2_int(depth + 1);
  endfunction

  // True when the depth, thresholds and read mode form a usable configuration.
  function automatic bit params_legal(input int depth, input int af, input int ae, input int mode);
    return (depth >= 2) && (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1) &&
           ((mode == MODE_REG) || (mode == MODE_FWFT));
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port storage array: synchronous write, combinational read.
// Contents are deliberately not reset.
module sfifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR  = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sfifo_flex.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost thresholds, error pulses and registered or first-word-fall-through read.
module sfifo_flex
  import sfifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR      = addr_bits(DEPTH),
  parameter int CNT_W     = cnt_bits(DEPTH),
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int MODE      = MODE_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             r_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  if (!params_legal(DEPTH, AF_THRESH, AE_THRESH, MODE)) begin : g_bad_params
    $error("sfifo_flex: illegal DEPTH/threshold/MODE combination");
  end

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);
  localparam logic [ADDR-1:0]  LAST_PTR = ADDR'(DEPTH - 1);

  logic [ADDR-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, next_count_s;
  logic             full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  logic             rd_ok_s, wr_ok_s;
  logic [WIDTH-1:0] ram_rdata_s;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [ADDR-1:0] ptr_inc(input logic [ADDR-1:0] p);
    if (p == LAST_PTR) begin
      return {ADDR{1'b0}};
    end else begin
      return p + ADDR'(1'b1);
    end
  endfunction

  // A read frees a slot, so a write into a full FIFO is legal alongside it.
  assign rd_ok_s = r_en & ~empty_r;
  assign wr_ok_s = wr_en & (~full_r | rd_ok_s);

  // Occupancy after the current edge
  always_comb begin
    next_count_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   next_count_s = count_r + CNT_W'(1'b1);
      2'b01:   next_count_s = count_r - CNT_W'(1'b1);
      default: next_count_s = count_r;
    endcase
  end

  // Pointers, count, status flags and error pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {ADDR{1'b0}};
      rd_ptr_r <= {ADDR{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= next_count_s;
      full_r  <= (next_count_s == DEPTH_C);
      empty_r <= (next_count_s == {CNT_W{1'b0}});
      af_r    <= (next_count_s >= AF_C);
      ae_r    <= (next_count_s <= AE_C);
      ovf_r   <= wr_en & ~wr_ok_s;
      udf_r   <= r_en & empty_r;
    end
  end

  sfifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok_s & rst),
    .waddr (wr_ptr_r),
    .wdata (din),
    .raddr (rd_ptr_r),
    .rdata (ram_rdata_s)
  );

  if (MODE == MODE_FWFT) begin : g_fwft
    assign dout = ram_rdata_s;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_r;

    // Registered read port
    always_ff @(posedge clk) begin
      if (!rst) begin
        dout_r <= {WIDTH{1'b0}};
      end else if (rd_ok_s) begin
        dout_r <= ram_rdata_s;
      end else begin
        dout_r <= dout_r;
      end
    end

    assign dout = dout_r;
  end

  assign count        = count_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_sfifo_flex.sv
// Bench for sfifo_flex: table-driven registered-mode vectors with a data
// scoreboard, plus FWFT and mid-operation reset sequences.
module tb_sfifo_flex;

  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic       clk;
  logic       rst;
  logic [7:0] din, dout;
  logic       wr_en, r_en;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  logic [7:0] f_din, f_dout;
  logic       f_wr, f_rd;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] f_count;

  int checks = 0;
  int errors = 0;

  sfifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .MODE(0)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .r_en(r_en), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sfifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .MODE(1)) dut_f (
    .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .r_en(f_rd), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [8:0] status; // {count, full, empty, almost_full, almost_empty, overflow, underflow}
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected flags are derived from the expected occupancy using the threshold definitions.
  function automatic logic [8:0] stat(input int cnt, input logic ov, input logic ud);
    logic [2:0] c;
    c = 3'(cnt);
    return {c, 1'(cnt == DEPTH), 1'(cnt == 0), 1'(cnt >= AF), 1'(cnt <= AE), ov, ud};
  endfunction

  task automatic add(input logic wr, input logic rd, input logic [7:0] d,
                     input int cnt, input logic ov, input logic ud);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.status = stat(cnt, ov, ud);
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         mc;
    logic       rd_ok, wr_ok, did_rd;
    logic [7:0] exp_dout;

    rst = 1'b0; wr_en = 1'b0; r_en = 1'b0; din = 8'h00;
    f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", {count, full, empty, almost_full, almost_empty, overflow, underflow}, stat(0, 1'b0, 1'b0));
    chk("reset_dout", dout, 8'h00);
    chk("reset_status_fwft", {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_udf}, stat(0, 1'b0, 1'b0));
    rst = 1'b1;

    // Fill to full, then overflow
    add(1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h44, 4, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h55, 5, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h66, 5, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 5, 1'b0, 1'b0);
    // Drain, then underflow
    for (int i = 4; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    // Pointer wrap across DEPTH-1 -> 0
    add(1'b1, 1'b0, 8'h01, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h02, 2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h03, 3, 1'b0, 1'b0);
    for (int i = 2; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'hB2, 2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'hC3, 3, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'hD4, 4, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i, 1'b0, 1'b0);
    // Full with simultaneous read and write
    for (int i = 1; i <= 5; i++) add(1'b1, 1'b0, 8'(8'h70 + i), i, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'hF6, 5, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i, 1'b0, 1'b0);
    // Empty with simultaneous read and write
    add(1'b1, 1'b1, 8'hE5, 1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0);

    mc = 0;
    exp_dout = 8'h00;
    foreach (vecs[i]) begin
      wr_en = vecs[i].wr; r_en = vecs[i].rd; din = vecs[i].din;
      rd_ok = vecs[i].rd && (mc != 0);
      wr_ok = vecs[i].wr && ((mc != DEPTH) || rd_ok);
      did_rd = 1'b0;
      if (rd_ok && sb.size() > 0) begin
        exp_dout = sb.pop_front();
        did_rd = 1'b1;
      end
      if (wr_ok) sb.push_back(vecs[i].din);
      if (wr_ok && !rd_ok) mc++;
      if (rd_ok && !wr_ok) mc--;
      tick();
      chk($sformatf("vec%0d_status", i),
          {count, full, empty, almost_full, almost_empty, overflow, underflow}, vecs[i].status);
      chk($sformatf(did_rd ? "vec%0d_dout_read" : "vec%0d_dout_hold", i), dout, exp_dout);
    end
    wr_en = 1'b0; r_en = 1'b0; din = 8'h00;
    chk("scoreboard_drained", sb.size(), 0);

    // FWFT: written word visible one cycle after its write edge
    f_wr = 1'b1; f_din = 8'h5A;
    tick();
    f_wr = 1'b0;
    chk("fwft_first_dout", f_dout, 8'h5A);
    chk("fwft_first_empty", f_empty, 1'b0);
    tick();
    chk("fwft_hold_dout", f_dout, 8'h5A);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("fwft_pop_status", {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_udf}, stat(0, 1'b0, 1'b0));
    for (int i = 1; i <= 3; i++) begin
      f_wr = 1'b1; f_din = 8'(8'h60 + i);
      tick();
    end
    f_wr = 1'b0;
    chk("fwft_count3", f_count, 3);
    chk("fwft_head", f_dout, 8'h61);

    // Reset mid-operation with requests in flight
    rst = 1'b0; f_wr = 1'b1; f_din = 8'h99; wr_en = 1'b1; din = 8'hAA;
    tick();
    rst = 1'b1; f_wr = 1'b0; wr_en = 1'b0;
    chk("midrst_status_fwft", {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_udf}, stat(0, 1'b0, 1'b0));
    chk("midrst_status_reg", {count, full, empty, almost_full, almost_empty, overflow, underflow}, stat(0, 1'b0, 1'b0));
    chk("midrst_dout_reg", dout, 8'h00);
    f_wr = 1'b1; f_din = 8'h77;
    tick();
    f_wr = 1'b0;
    chk("postrst_fwft_dout", f_dout, 8'h77);
    chk("postrst_fwft_count", f_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
